mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Multicycle MIPS-subset core: one finite-state machine sequences each instruction through fetch, decode, execute, memory and writeback.
- A single shared ALU, an internal 32x32 register file and one unified memory port are reused across cycles.
- Memory uses a valid/ready handshake, so it may take any number of wait states.
- Adds parametrised address width and reset vector, a halt/resume state, illegal-instruction and misalignment trapping, and a retire pulse for debug and performance counting.

Parameters:
- ADDR_W, 32, width of PC and mem_addr (8..32); the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset (word-aligned).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- halt  in  1  request to stop at the next instruction boundary.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  store data.
- mem_ready  in  1  transfer completes at the edge where mem_req=1 and mem_ready=1.
- mem_rdata  in  32  read data, sampled at the completing edge.
- pc_out  out  ADDR_W  current PC.
- state_out  out  3  FSM state encoding.
- retired  out  1  one-cycle pulse per committed instruction.
- halted  out  1  core is in the HALT state.
- trap  out  1  sticky fault indicator.

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH, PC=RESET_PC, all 32 registers=0, IR=0.
  - retired=0, halted=0, trap=0, mem_we=0.
  - mem_req rises in the first cycle after reset_n deasserts.
  - Reset mid-transfer aborts the transfer with no register or PC update.
- States and state_out encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- mem_req=1 exactly in FETCH and MEM. mem_addr, mem_we and mem_wdata are held stable until completion. mem_ready outside a request is ignored.
- FETCH:
  - Read at PC; the FSM stays in FETCH until the transfer completes.
  - On completion: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Latch rs and rt operands, sign-extend imm16.
  - Compute branch target = PC + (sext(imm)<<2), using the already-incremented PC.
  - Unknown opcode or funct: go to TRAP.
- EXEC:
  - R-type, opcode 0x00: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Result goes to rd; next state WB.
  - addi (0x08): result goes to rt; next state WB.
  - lw (0x23) / sw (0x2B): address = rs + sext(imm).
    - If addr[1:0]!=0, go to TRAP.
    - Otherwise go to MEM.
  - beq (0x04) / bne (0x05): if taken, PC<=target. The instruction commits here.
  - j (0x02): PC<={PC[31:28], imm26, 2'b00} truncated to ADDR_W. The instruction commits here.
- MEM:
  - lw: read; on completion MDR<=mem_rdata, go to WB.
  - sw: write rt data; commits on completion.
- WB: write the result to the destination register. Writes to $0 are discarded; $0 always reads 0.
- Arithmetic: 32-bit wraparound, no overflow trap. PC arithmetic is modulo 2^ADDR_W.
- Cycle counts with zero wait states:
  - beq, bne, j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- retired: registered pulse, high for the single cycle after the committing edge.
- halt:
  - Sampled only at a commit edge. If halt=1, the next state is HALT instead of FETCH; otherwise FETCH.
  - In HALT: halted=1, mem_req=0, no state changes. halt=0 returns to FETCH at the same PC the next cycle.
  - A halt assertion mid-instruction never aborts that instruction.
- TRAP:
  - trap=1, mem_req=0, PC holds the address of the faulting instruction + 4.
  - TRAP is left only by reset; halt is ignored in TRAP.

Test Plan:
- Reset with RESET_PC=0x100, mem_ready tied 1 → first request mem_addr=0x100, mem_we=0. `addi $1,$0,5` → $1=5, retired pulses 4 cycles after the request began.
- Memory wait states: mem_ready low 3 cycles during FETCH of `add $3,$1,$2` ($1=7, $2=0xFFFFFFFF) → mem_addr stable throughout, $3=6, total 7 cycles. Then `sub $4,$2,$1` → $4=0xFFFFFFF8.
- `sw $1,8($0)` then `lw $5,8($0)` → write request addr=8, wdata=5; read returns 5, $5=5 at the WB commit; lw takes 5 cycles. `addi $0,$0,9` → $0 still reads 0.
- `beq $1,$1,-1` at 0x104 → PC=0x104 after 3 cycles, looping. `bne` with equal operands → PC=0x108. `j 0x40` → PC=0x100.
- halt raised during EXEC of an addi → the addi commits, state_out=5, halted=1, mem_req=0 for 10 cycles. halt released → FETCH at the next sequential PC.
- Opcode 0x3F → state_out=6, trap=1, no further requests. `lw` at address 0x6 → TRAP, register unchanged. reset_n pulse low → trap=0, PC=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Unified memory port of the multicycle MIPS core.
//   master (core):   mem_req, mem_we, mem_addr, mem_wdata out; mem_ready, mem_rdata in
//   slave  (memory): the mirror image
// A transfer completes at the rising edge where mem_req=1 and mem_ready=1.
interface mips_multicycle_core_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq, bne, j).
// One FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB, reusing a
// single ALU and one handshaked memory port.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   halt            stop at the next commit; released -> resume at same PC
//   mem             memory bus (master side of mips_multicycle_core_if)
//   pc_out          current PC
//   state_out       FSM state (FETCH=0 .. TRAP=6)
//   retired         one-cycle pulse after each committing edge
//   halted          core sits in HALT
//   trap            core sits in TRAP (left only by reset)
module mips_multicycle_core #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   halt,
    mips_multicycle_core_if.master mem,
    output logic [ADDR_W-1:0]      pc_out,
    output logic [2:0]             state_out,
    output logic                   retired,
    output logic                   halted,
    output logic                   trap
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, target;
    logic [31:0]       ir, a_reg, b_reg, imm_ext, alu_out, mdr;
    logic [31:0]       regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_dest;
    logic [4:0]  unused_shamt;
    logic        is_r, is_lw, is_sw, is_branch, legal, br_taken, commit;
    logic [31:0] pc_ext, j_target, alu_a, alu_b, alu_y;
    alu_op_t     alu_op;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ir[10:6];
    assign is_r         = (opcode == OP_R);
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign wb_dest      = is_r ? rd : rt;

    always_comb begin
        pc_ext = '0;
        pc_ext[ADDR_W-1:0] = pc;
    end

    // pc is already PC+4 when EXEC runs, so its top nibble is the MIPS region.
    assign j_target = {pc_ext[31:28], ir[25:0], 2'b00};

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:    legal = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Shared ALU: PC+4 in FETCH, branch target in DECODE, operation in EXEC.
    always_comb begin
        alu_a  = a_reg;
        alu_b  = imm_ext;
        alu_op = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_a = pc_ext;
                alu_b = 32'd4;
            end
            S_DECODE: begin
                alu_a = pc_ext;
                alu_b = {{14{ir[15]}}, ir[15:0], 2'b00};
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_b = b_reg;
                    case (funct)
                        6'h22:   alu_op = ALU_SUB;
                        6'h24:   alu_op = ALU_AND;
                        6'h25:   alu_op = ALU_OR;
                        6'h2A:   alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                end else if (is_branch) begin
                    alu_b  = b_reg;
                    alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    assign br_taken = (opcode == OP_BEQ) ? (alu_y == '0) : (alu_y != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            S_FETCH:  if (mem.mem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW:        state_nx = (alu_y[1:0] != 2'b00) ? S_TRAP : S_MEM;
                    OP_BEQ, OP_BNE, OP_J: commit  = 1'b1;
                    default:             state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    if (is_lw) state_nx = S_WB;
                    else       commit   = 1'b1;
                end
            end
            S_WB:    commit = 1'b1;
            S_HALT:  if (!halt) state_nx = S_FETCH;
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase
        if (commit) state_nx = halt ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC[ADDR_W-1:0];
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm_ext <= '0;
            target  <= '0;
            alu_out <= '0;
            mdr     <= '0;
            retired <= 1'b0;
            regs    <= '{default: '0};
        end else begin
            retired <= commit;
            case (state)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        ir <= mem.mem_rdata;
                        pc <= alu_y[ADDR_W-1:0];
                    end
                end
                S_DECODE: begin
                    a_reg   <= regs[rs];
                    b_reg   <= regs[rt];
                    imm_ext <= {{16{ir[15]}}, ir[15:0]};
                    target  <= alu_y[ADDR_W-1:0];
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    if (is_branch && br_taken) pc <= target;
                    else if (opcode == OP_J)   pc <= j_target[ADDR_W-1:0];
                end
                S_MEM: if (mem.mem_ready && is_lw) mdr <= mem.mem_rdata;
                S_WB: begin
                    // $0 is never written, so reading regs[0] always yields 0.
                    if (wb_dest != 5'd0) regs[wb_dest] <= is_lw ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

    // Gated by reset_n so no request is visible while reset is held.
    assign mem.mem_req   = reset_n && ((state == S_FETCH) || (state == S_MEM));
    assign mem.mem_we    = (state == S_MEM) && is_sw;
    assign mem.mem_addr  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem.mem_wdata = b_reg;

    assign pc_out    = pc;
    assign state_out = state;
    assign halted    = (state == S_HALT);
    assign trap      = (state == S_TRAP);
endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;
    localparam int unsigned AW  = 16;
    localparam logic [31:0] RPC = 32'h100;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          halt    = 1'b0;
    logic [AW-1:0] pc_out;
    logic [2:0]    state_out;
    logic          retired, halted, trap;

    mips_multicycle_core_if #(.ADDR_W(AW)) bus ();

    mips_multicycle_core #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .halt      (halt),
        .mem       (bus),
        .pc_out    (pc_out),
        .state_out (state_out),
        .retired   (retired),
        .halted    (halted),
        .trap      (trap)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:4095];   // bench memory, word index = addr[13:2]
    logic [31:0] mm  [0:4095];   // reference model's private copy
    bit          rand_ready = 1'b0;
    bit          halt_en    = 1'b0;
    int          n_checks   = 0;
    int          n_pass     = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } txn_t;
    txn_t exp_txn [$];
    int   exp_cyc [$];

    function automatic int idx(input logic [AW-1:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ISA-level reference: executes the program in mm, producing the bus
    // transactions and per-instruction zero-wait cycle costs in order.
    task automatic model_run(output logic [AW-1:0] trap_pc);
        logic [31:0]   r [32];
        logic [AW-1:0] pc;
        logic [31:0]   ins, a, b, sx, ea, res, pc32, jt;
        bit            done;
        for (int i = 0; i < 32; i++) r[i] = '0;
        pc   = RPC[AW-1:0];
        done = 1'b0;
        for (int steps = 0; steps < 2000 && !done; steps++) begin
            exp_txn.push_back('{1'b0, pc, 32'h0});
            ins = mm[idx(pc)];
            pc  = pc + AW'(4);
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            sx  = {{16{ins[15]}}, ins[15:0]};
            res = '0;
            case (ins[31:26])
                6'h00: begin
                    case (ins[5:0])
                        6'h20:   res = a + b;
                        6'h22:   res = a - b;
                        6'h24:   res = a & b;
                        6'h25:   res = a | b;
                        6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: done = 1'b1;
                    endcase
                    if (!done) begin
                        r[ins[15:11]] = res;
                        exp_cyc.push_back(4);
                    end
                end
                6'h08: begin
                    r[ins[20:16]] = a + sx;
                    exp_cyc.push_back(4);
                end
                6'h23: begin
                    ea = a + sx;
                    if (ea[1:0] != 2'b00) done = 1'b1;
                    else begin
                        exp_txn.push_back('{1'b0, ea[AW-1:0], 32'h0});
                        r[ins[20:16]] = mm[idx(ea[AW-1:0])];
                        exp_cyc.push_back(5);
                    end
                end
                6'h2B: begin
                    ea = a + sx;
                    if (ea[1:0] != 2'b00) done = 1'b1;
                    else begin
                        exp_txn.push_back('{1'b1, ea[AW-1:0], b});
                        mm[idx(ea[AW-1:0])] = b;
                        exp_cyc.push_back(4);
                    end
                end
                6'h04, 6'h05: begin
                    if ((a == b) == (ins[31:26] == 6'h04)) pc = pc + AW'(sx << 2);
                    exp_cyc.push_back(3);
                end
                6'h02: begin
                    pc32 = 32'(pc);
                    jt   = {pc32[31:28], ins[25:0], 2'b00};
                    pc   = jt[AW-1:0];
                    exp_cyc.push_back(3);
                end
                default: done = 1'b1;
            endcase
            r[0] = '0;
        end
        trap_pc = pc;
    endtask

    // Memory slave: random wait states in random runs; stores land when the
    // completing cycle is known (before the edge that completes them).
    always begin
        @(posedge clock);
        #1;
        bus.mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.mem_rdata = mem[idx(bus.mem_addr)];
        if (bus.mem_req && bus.mem_ready && bus.mem_we)
            mem[idx(bus.mem_addr)] = bus.mem_wdata;
    end

    always begin
        @(posedge clock);
        #1;
        if (!halt_en)                         halt = 1'b0;
        else if ($urandom_range(0, 7) == 0)   halt = ~halt;
    end

    // Monitor: pops the scoreboards on completed transfers and retire pulses.
    int            cnt = -1, waits = 0, halts = 0, base;
    logic          prev_req = 1'b0, prev_ready = 1'b1, prev_halted = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_wdata = '0;
    txn_t          e;

    always @(negedge clock) begin
        if (!reset_n) begin
            cnt = -1; waits = 0; halts = 0;
            prev_req = 1'b0; prev_halted = 1'b0;
        end else begin
            cnt++;
            if (retired) begin
                if (exp_cyc.size() == 0) begin
                    n_checks++;
                    $display("FAIL retire_extra: retire pulse at pc %h, model expected none", pc_out);
                end else begin
                    base = exp_cyc.pop_front();
                    chk("retire_cycles", cnt, base + waits + halts);
                end
                cnt = 0; waits = 0; halts = 0;
            end
            if (bus.mem_req && !bus.mem_ready) waits++;
            if (halted) begin
                halts++;
                chk("halt_no_req", bus.mem_req, 0);
                if (!prev_halted) chk("halt_on_commit", retired, 1);
            end
            if (bus.mem_req && prev_req && !prev_ready) begin
                chk("addr_stable", bus.mem_addr, prev_addr);
                chk("we_stable", bus.mem_we, prev_we);
                if (bus.mem_we) chk("wdata_stable", bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_req && bus.mem_ready) begin
                if (exp_txn.size() == 0) begin
                    n_checks++;
                    $display("FAIL txn_extra: request addr %h we %b, model expected none", bus.mem_addr, bus.mem_we);
                end else begin
                    e = exp_txn.pop_front();
                    chk("txn_we", bus.mem_we, e.we);
                    chk("txn_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("txn_wdata", bus.mem_wdata, e.data);
                end
            end
            prev_req    = bus.mem_req;
            prev_ready  = bus.mem_ready;
            prev_addr   = bus.mem_addr;
            prev_we     = bus.mem_we;
            prev_wdata  = bus.mem_wdata;
            prev_halted = halted;
        end
    end

    task automatic clear_mem(input bit rnd_data);
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        if (rnd_data)
            for (int i = 0; i < 16; i++) mem[512 + i] = $urandom;
    endtask

    task automatic load_directed();
        logic [31:0] p [19];
        p[0]  = enc_i(6'h08, 0, 1, 16'd7);          // addi $1,$0,7
        p[1]  = enc_i(6'h08, 0, 2, 16'hFFFF);       // addi $2,$0,-1
        p[2]  = enc_r(1, 2, 3, 6'h20);              // add  $3,$1,$2
        p[3]  = enc_r(2, 1, 4, 6'h22);              // sub  $4,$2,$1
        p[4]  = enc_i(6'h2B, 0, 3, 16'h0800);       // sw   $3,0x800
        p[5]  = enc_i(6'h2B, 0, 4, 16'h0804);       // sw   $4,0x804
        p[6]  = enc_i(6'h23, 0, 5, 16'h0800);       // lw   $5,0x800
        p[7]  = enc_i(6'h08, 0, 0, 16'd9);          // addi $0,$0,9
        p[8]  = enc_i(6'h2B, 0, 0, 16'h0808);       // sw   $0,0x808
        p[9]  = enc_i(6'h2B, 0, 5, 16'h080C);       // sw   $5,0x80C
        p[10] = enc_i(6'h05, 1, 1, 16'd4);          // bne  $1,$1 (not taken)
        p[11] = enc_i(6'h04, 1, 1, 16'd1);          // beq  $1,$1,+1
        p[12] = enc_i(6'h08, 0, 6, 16'd1);          // skipped
        p[13] = enc_j(32'h13C);                     // j    0x13C
        p[14] = enc_i(6'h08, 0, 6, 16'd2);          // skipped
        p[15] = enc_r(2, 1, 7, 6'h2A);              // slt  $7,$2,$1
        p[16] = enc_i(6'h2B, 0, 7, 16'h0810);       // sw   $7,0x810
        p[17] = enc_i(6'h2B, 0, 6, 16'h0814);       // sw   $6,0x814
        p[18] = enc_i(6'h23, 0, 8, 16'h0006);       // lw   $8,6 -> misaligned
        clear_mem(1'b0);
        for (int i = 0; i < 19; i++) mem[64 + i] = p[i];
    endtask

    task automatic load_random();
        logic [5:0]  fns [5];
        logic [31:0] tgt;
        int          k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_mem(1'b1);
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 6))
                0: mem[64 + i] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                1, 2: mem[64 + i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                          fns[$urandom_range(0, 4)]);
                3: mem[64 + i] = enc_i(6'h2B, 0, $urandom_range(0, 7), 16'h0800 + 16'(4 * $urandom_range(0, 15)));
                4: mem[64 + i] = enc_i(6'h23, 0, $urandom_range(0, 7), 16'h0800 + 16'(4 * $urandom_range(0, 15)));
                5: mem[64 + i] = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, $urandom_range(0, 7),
                                       $urandom_range(0, 7), 16'(k));
                default: begin
                    tgt = RPC + 32'(4 * (i + 1 + k));
                    mem[64 + i] = enc_j(tgt);
                end
            endcase
        end
        for (int r = 1; r < 8; r++) mem[64 + 29 + r] = enc_i(6'h2B, 0, r, 16'h0900 + 16'(4 * r));
        case ($urandom_range(0, 3))
            0: mem[64 + 37] = 32'hFC00_0000;
            1: mem[64 + 37] = enc_r(1, 2, 3, 6'h3F);
            2: mem[64 + 37] = enc_i(6'h23, 0, 1, 16'h0806);
            default: mem[64 + 37] = enc_i(6'h2B, 0, 1, 16'h0803);
        endcase
    endtask

    task automatic run_prog(input bit rnd, input string tag);
        logic [AW-1:0] tpc;
        int            cyc;
        exp_txn.delete();
        exp_cyc.delete();
        for (int i = 0; i < 4096; i++) mm[i] = mem[i];
        model_run(tpc);
        halt_en    = 1'b0;
        reset_n    = 1'b0;
        rand_ready = rnd;
        repeat (3) @(negedge clock);
        chk("reset_pc", pc_out, RPC[AW-1:0]);
        chk("reset_state", state_out, 0);
        chk("reset_trap", trap, 0);
        chk("reset_halted", halted, 0);
        chk("reset_retired", retired, 0);
        chk("reset_req", bus.mem_req, 0);
        chk("reset_we", bus.mem_we, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        halt_en = rnd;
        cyc = 0;
        while (!trap && cyc < 6000) begin
            @(negedge clock);
            cyc++;
        end
        if (!trap) begin
            n_checks++;
            $display("FAIL %s_timeout: trap not reached after %0d cycles, required trap=1", tag, cyc);
        end
        halt_en = 1'b0;
        repeat (4) @(negedge clock);
        chk("end_state", state_out, 6);
        chk("end_trap", trap, 1);
        chk("end_halted", halted, 0);
        chk("end_no_req", bus.mem_req, 0);
        chk("end_pc", pc_out, tpc);
        chk("end_txn_left", exp_txn.size(), 0);
        chk("end_retire_left", exp_cyc.size(), 0);
    endtask

    initial begin
        load_directed();
        run_prog(1'b0, "directed");
        chk("dir_add", mem[512], 32'd6);
        chk("dir_sub", mem[513], 32'hFFFF_FFF8);
        chk("dir_r0", mem[514], 32'd0);
        chk("dir_lw", mem[515], 32'd6);
        chk("dir_slt", mem[516], 32'd1);
        chk("dir_skipped", mem[517], 32'd0);
        chk("dir_trap_pc", pc_out, 16'h014C);
        for (int r = 0; r < 4; r++) begin
            load_random();
            run_prog(1'b1, "random");
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
